// File: rtl/wheel_spin_ctrl_pkg.sv
// rtl/wheel_spin_ctrl_pkg.sv - shared wheel definitions: state codes, pocket geometry, modulo helper
// Contents:
//   POCKETS_DEFAULT  pocket count of a single-zero wheel
//   POCKET_W         width of pocket indices
//   CNT_W            width of the steps/interval/tick counters
//   ST_*             controller state encodings
//   mod_pockets()    single conditional subtraction, valid for v < 2*p
package wheel_spin_ctrl_pkg;

  localparam int POCKETS_DEFAULT = 37;
  localparam int POCKET_W        = 6;
  localparam int CNT_W           = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SPIN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The seed is a 6-bit value (< 64 < 2*37), so one subtraction fully
  // reduces it.
  function automatic logic [6:0] mod_pockets(input logic [6:0] v, input logic [6:0] p);
    return (v >= p) ? (v - p) : v;
  endfunction

endpackage

// File: rtl/wheel_spin_ctrl_step_timer.sv
// rtl/wheel_spin_ctrl_step_timer.sv - pocket-step divider with per-step deceleration
// Ports:
//   clk       in   system clock
//   clr       in   synchronous active-high reset
//   load      in   restart: tick=0, interval=BASE_DIV
//   run       in   count while the wheel is spinning
//   decel     in   lengthen the interval by DIV_INC on the current step
//   step_now  out  combinational: this edge advances the pocket
module step_timer
  import wheel_spin_ctrl_pkg::*;
#(
  parameter int BASE_DIV = 4,
  parameter int DIV_INC  = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic run,
  input  logic decel,
  output logic step_now
);

  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] interval;

  assign step_now = run && (tick == (interval - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (clr) begin
      tick     <= '0;
      interval <= CNT_W'(BASE_DIV);
    end else if (load) begin
      tick     <= '0;
      interval <= CNT_W'(BASE_DIV);
    end else if (run) begin
      if (step_now) begin
        tick <= '0;
        // The new interval applies to the step that starts now.
        if (decel) begin
          interval <= interval + CNT_W'(DIV_INC);
        end
      end else begin
        tick <= tick + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wheel_spin_ctrl.sv
// rtl/wheel_spin_ctrl.sv - roulette spin controller: seed reduction, lap walk, landing
// Ports:
//   clk     in   system clock
//   clr     in   synchronous active-high reset, overrides everything
//   spin    in   spin request level, sampled only in IDLE
//   seed    in   free-running 6-bit counter value
//   pocket  out  currently displayed pocket
//   step    out  one-cycle pulse after pocket advances
//   busy    out  high in SPIN and DONE
//   done    out  one-cycle pulse on landing
//   result  out  landed pocket, held until the next landing
module wheel_spin_ctrl
  import wheel_spin_ctrl_pkg::*;
#(
  parameter int POCKETS  = POCKETS_DEFAULT,
  parameter int LAPS     = 3,
  parameter int BASE_DIV = 4,
  parameter int DIV_INC  = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                spin,
  input  logic [POCKET_W-1:0] seed,
  output logic [POCKET_W-1:0] pocket,
  output logic                step,
  output logic                busy,
  output logic                done,
  output logic [POCKET_W-1:0] result
);

  logic [1:0]          state;
  logic [CNT_W-1:0]    steps;

  logic [6:0]          seed7;
  logic [6:0]          target7;
  logic [6:0]          pocket7;
  logic [6:0]          dist7;
  logic [CNT_W-1:0]    load_steps;
  logic [POCKET_W-1:0] next_pocket;
  logic                load;
  logic                run;
  logic                decel;
  logic                step_now;

  assign seed7   = {1'b0, seed};
  assign target7 = mod_pockets(seed7, 7'(POCKETS));
  assign pocket7 = {1'b0, pocket};

  // Forward distance from the current pocket to the target around the wheel.
  assign dist7 = (target7 >= pocket7) ? (target7 - pocket7)
                                      : (target7 + 7'(POCKETS) - pocket7);

  assign load_steps  = CNT_W'(LAPS * POCKETS) + {1'b0, dist7};
  assign next_pocket = (pocket == POCKET_W'(POCKETS - 1)) ? '0 : pocket + POCKET_W'(1);

  assign load  = (state == ST_IDLE) && spin;
  assign run   = (state == ST_SPIN);
  // Remaining-after-this-step below one lap: the landing lap slows down.
  assign decel = (steps - CNT_W'(1)) < CNT_W'(POCKETS);

  step_timer #(
    .BASE_DIV (BASE_DIV),
    .DIV_INC  (DIV_INC)
  ) u_step_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .run      (run),
    .decel    (decel),
    .step_now (step_now)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= ST_IDLE;
      steps  <= '0;
      pocket <= '0;
      result <= '0;
      step   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // pocket is deliberately left at the last landing position.
          if (spin) begin
            steps <= load_steps;
            busy  <= 1'b1;
            state <= ST_SPIN;
          end
        end
        ST_SPIN: begin
          if (step_now) begin
            pocket <= next_pocket;
            step   <= 1'b1;
            steps  <= steps - CNT_W'(1);
            if (steps == CNT_W'(1)) begin
              result <= next_pocket;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wheel_spin_ctrl.sv
// tb/tb_wheel_spin_ctrl.sv - scoreboard bench for wheel_spin_ctrl
module tb_wheel_spin_ctrl;

  localparam int P = 37;
  localparam int L = 3;
  localparam int B = 4;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       spin = 1'b0;
  logic [5:0] seed = '0;
  logic [5:0] pocket, result;
  logic       step, busy, done;

  logic       clr1 = 1'b1;
  logic       spin1 = 1'b0;
  logic [5:0] seed1 = '0;
  logic [5:0] pocket1, result1;
  logic       step1, busy1, done1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int tgt;
    int st;
    int dcyc;
    int wraps;
  } exp_t;
  exp_t sb[$];

  int exp_pocket = 0;
  int mon_pocket = 0;
  int mon_steps = 0;
  int mon_wraps = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wheel_spin_ctrl dut (
    .clk(clk), .clr(clr), .spin(spin), .seed(seed),
    .pocket(pocket), .step(step), .busy(busy), .done(done), .result(result)
  );

  wheel_spin_ctrl #(.LAPS(1)) dut1 (
    .clk(clk), .clr(clr1), .spin(spin1), .seed(seed1),
    .pocket(pocket1), .step(step1), .busy(busy1), .done(done1), .result(result1)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: follows the wheel from the DUT's step/done pulses.
  always @(posedge clk) begin
    #1;
    if (clr) begin
      mon_pocket = 0;
      mon_steps = 0;
      mon_wraps = 0;
      chk("clr_outputs", int'({pocket, result, step, busy, done}), 0);
    end else begin
      if (step) begin
        mon_pocket = (mon_pocket + 1) % P;
        mon_steps++;
        if (mon_pocket == 0) mon_wraps++;
        chk("step_pocket", int'(pocket), mon_pocket);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", int'(result), e.tgt);
          chk("landed_pocket", int'(pocket), e.tgt);
          chk("step_count", mon_steps, e.st);
          chk("done_cycle", cyc, e.dcyc);
          chk("wraps", mon_wraps, e.wraps);
          chk("busy_at_done", int'(busy), 1);
        end
        mon_steps = 0;
        mon_wraps = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 4000; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    chk("done_timeout", sb.size(), 0);
    sb.delete();
  endtask

  // Issues a spin and pushes the model's prediction; optionally pokes spin mid-spin.
  task automatic do_spin(input logic [5:0] s, input bit poke, input bit wait_land);
    exp_t e;
    wait_idle();
    e.tgt   = int'(s) % P;
    e.st    = L * P + ((e.tgt - exp_pocket + P) % P);
    e.dcyc  = cyc + 1 + e.st * B + D * (36 * 37 / 2);
    e.wraps = (exp_pocket + e.st) / P;
    sb.push_back(e);
    exp_pocket = e.tgt;
    seed = s;
    spin = 1'b1;
    @(negedge clk);
    spin = 1'b0;
    seed = 6'($urandom);
    if (poke) begin
      repeat (200 + $urandom_range(0, 100)) @(negedge clk);
      spin = 1'b1;
      seed = 6'($urandom);
      @(negedge clk);
      spin = 1'b0;
    end
    if (wait_land) wait_empty();
  endtask

  initial begin
    int n;
    int c0;
    int dcyc;

    // Reset and idle
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({pocket, result, step, busy, done}), 0);
    end

    // Minimal landing lap on the LAPS=1 instance
    clr1 = 1'b0;
    @(negedge clk);
    c0 = cyc;
    seed1 = 6'd0;
    spin1 = 1'b1;
    @(negedge clk);
    spin1 = 1'b0;
    n = 0;
    dcyc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (step1) n++;
      if (done1) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("laps1_steps", n, 37);
    chk("laps1_done_latency", dcyc - (c0 + 1), 1480);
    chk("laps1_result", int'(result1), 0);

    // Seed >= 37, then chained spin
    do_spin(6'd40, 1'b0, 1'b1);
    do_spin(6'd63, 1'b1, 1'b1);

    // Randomized spins, some with an ignored mid-spin request
    for (int i = 0; i < 5; i++) begin
      do_spin(6'($urandom), 1'($urandom), 1'b1);
    end

    // spin and clr together in IDLE: clr wins
    wait_idle();
    @(negedge clk);
    spin = 1'b1;
    clr = 1'b1;
    seed = 6'($urandom);
    @(negedge clk);
    spin = 1'b0;
    clr = 1'b0;
    exp_pocket = 0;
    repeat (3) begin
      @(negedge clk);
      chk("spin_clr_busy", int'(busy), 0);
    end

    // Reset at step 60
    do_spin(6'($urandom), 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 2000 && n < 60; i++) begin
      @(negedge clk);
      if (step) n++;
    end
    chk("reach_step60", n, 60);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sb.delete();
    exp_pocket = 0;
    chk("midspin_pocket", int'(pocket), 0);
    chk("midspin_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("post_clr_busy", int'(busy), 0);

    // Recovery spin from pocket 0
    do_spin(6'($urandom), 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
